// File: rtl/exu_wbck_arb.sv
// exu_wbck_arb: LSU-priority regfile write-back arbiter with ALU starvation promotion; WBCK_ARB_REG_OUT_EN registers the regfile write
`ifndef XLEN
`define XLEN 32
`endif
`ifndef RFIDX_WIDTH
`define RFIDX_WIDTH 5
`endif
module exu_wbck_arb #(
  parameter int STARVE_MAX = 4,
  parameter int CNT_W = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    alu_wbck_i_valid,
  output logic                    alu_wbck_i_ready,
  input  logic [`XLEN-1:0]        alu_wbck_i_wdat,
  input  logic [`RFIDX_WIDTH-1:0] alu_wbck_i_rdidx,
  input  logic                    lsu_wbck_i_valid,
  output logic                    lsu_wbck_i_ready,
  input  logic [`XLEN-1:0]        lsu_wbck_i_wdat,
  input  logic [`RFIDX_WIDTH-1:0] lsu_wbck_i_rdidx,
  output logic                    rf_wbck_o_ena,
  output logic [`XLEN-1:0]        rf_wbck_o_wdat,
  output logic [`RFIDX_WIDTH-1:0] rf_wbck_o_rdidx,
  output logic                    arb_o_alu_prio
);
  logic [CNT_W-1:0] starv_cnt;
  logic alu_gnt, lsu_gnt, mux_ena;
  logic [`XLEN-1:0] mux_wdat;
  logic [`RFIDX_WIDTH-1:0] mux_rdidx;
  assign arb_o_alu_prio = starv_cnt == CNT_W'(STARVE_MAX);
  // grant selection and write mux; nothing is granted while in reset, and x0 writes handshake but never enable
  always_comb begin
    alu_gnt = ~rst & alu_wbck_i_valid & (~lsu_wbck_i_valid | arb_o_alu_prio);
    lsu_gnt = ~rst & lsu_wbck_i_valid & ~alu_gnt;
    mux_wdat = alu_gnt ? alu_wbck_i_wdat : lsu_gnt ? lsu_wbck_i_wdat : '0;
    mux_rdidx = alu_gnt ? alu_wbck_i_rdidx : lsu_gnt ? lsu_wbck_i_rdidx : '0;
    mux_ena = (alu_gnt | lsu_gnt) & (mux_rdidx != '0);
  end
  assign alu_wbck_i_ready = alu_gnt;
  assign lsu_wbck_i_ready = lsu_gnt;
  // starvation counter: cleared by any ALU grant, counts ALU-denied cycles up to the promotion threshold
  always_ff @(posedge clk or posedge rst) begin
    if (rst) starv_cnt <= '0;
    else if (alu_gnt) starv_cnt <= '0;
    else if (alu_wbck_i_valid & lsu_gnt & ~arb_o_alu_prio) starv_cnt <= starv_cnt + CNT_W'(1);
  end
`ifdef WBCK_ARB_REG_OUT_EN
  // retimed regfile write; an in-flight write is dropped on reset
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rf_wbck_o_ena <= 1'b0;
      rf_wbck_o_wdat <= '0;
      rf_wbck_o_rdidx <= '0;
    end else begin
      rf_wbck_o_ena <= mux_ena;
      rf_wbck_o_wdat <= mux_wdat;
      rf_wbck_o_rdidx <= mux_rdidx;
    end
  end
`else
  assign rf_wbck_o_ena = mux_ena;
  assign rf_wbck_o_wdat = mux_wdat;
  assign rf_wbck_o_rdidx = mux_rdidx;
`endif
endmodule

// File: tb/tb_exu_wbck_arb.sv
// tb_exu_wbck_arb: directed stimulus against a cycle model of the write-back arbiter
`ifndef XLEN
`define XLEN 32
`endif
`ifndef RFIDX_WIDTH
`define RFIDX_WIDTH 5
`endif
module tb_exu_wbck_arb;
  localparam int SM = 4;
  localparam int XL = `XLEN;
  localparam int RW = `RFIDX_WIDTH;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic av, lv, a_rdy, l_rdy, rf_ena, prio;
  logic [XL-1:0] aw, lw, rf_wdat;
  logic [RW-1:0] ai, li, rf_idx;
  int checks = 0;
  int errors = 0;
  int m_cnt = 0;
  logic m_ga, m_gl, m_ena, q_ena;
  logic [XL-1:0] m_wdat, q_wdat;
  logic [RW-1:0] m_idx, q_idx;
  always #5 clk = ~clk;
  exu_wbck_arb #(.STARVE_MAX(SM), .CNT_W(4)) dut (
    .clk(clk), .rst(rst),
    .alu_wbck_i_valid(av), .alu_wbck_i_ready(a_rdy), .alu_wbck_i_wdat(aw), .alu_wbck_i_rdidx(ai),
    .lsu_wbck_i_valid(lv), .lsu_wbck_i_ready(l_rdy), .lsu_wbck_i_wdat(lw), .lsu_wbck_i_rdidx(li),
    .rf_wbck_o_ena(rf_ena), .rf_wbck_o_wdat(rf_wdat), .rf_wbck_o_rdidx(rf_idx),
    .arb_o_alu_prio(prio)
  );
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask
  task automatic drive(input logic a_v, input logic [RW-1:0] a_i, input logic [XL-1:0] a_w,
                       input logic l_v, input logic [RW-1:0] l_i, input logic [XL-1:0] l_w);
    av = a_v; ai = a_i; aw = a_w; lv = l_v; li = l_i; lw = l_w;
  endtask
  task automatic half();
    @(negedge clk);
    if (rst) begin
      m_cnt = 0;
      q_ena = 1'b0; q_wdat = '0; q_idx = '0;
    end
    m_ga = !rst && av && (!lv || m_cnt == SM);
    m_gl = !rst && lv && !m_ga;
    m_wdat = m_ga ? aw : m_gl ? lw : '0;
    m_idx = m_ga ? ai : m_gl ? li : '0;
    m_ena = (m_ga || m_gl) && m_idx != 0;
    chk("alu_ready", 64'(a_rdy), 64'(m_ga));
    chk("lsu_ready", 64'(l_rdy), 64'(m_gl));
    chk("alu_prio", 64'(prio), 64'(m_cnt == SM));
    chk("starv_cnt", 64'(dut.starv_cnt), 64'(m_cnt));
`ifdef WBCK_ARB_REG_OUT_EN
    chk("rf_ena", 64'(rf_ena), 64'(q_ena));
    chk("rf_wdat", 64'(rf_wdat), 64'(q_wdat));
    chk("rf_idx", 64'(rf_idx), 64'(q_idx));
`else
    chk("rf_ena", 64'(rf_ena), 64'(m_ena));
    chk("rf_wdat", 64'(rf_wdat), 64'(m_wdat));
    chk("rf_idx", 64'(rf_idx), 64'(m_idx));
`endif
  endtask
  task automatic fin();
    @(posedge clk);
    if (rst) begin
      m_cnt = 0;
      q_ena = 1'b0; q_wdat = '0; q_idx = '0;
    end else begin
      if (m_ga) m_cnt = 0;
      else if (av && m_gl && m_cnt < SM) m_cnt++;
      q_ena = m_ena; q_wdat = m_wdat; q_idx = m_idx;
    end
    #1;
  endtask
  task automatic cyc();
    half();
    fin();
  endtask
  initial begin
    drive(1'b1, 5'd3, 32'h1, 1'b1, 5'd4, 32'h2);
    half();
    chk("reset_alu_ready", 64'(a_rdy), 64'd0);
    chk("reset_lsu_ready", 64'(l_rdy), 64'd0);
    chk("reset_prio", 64'(prio), 64'd0);
    chk("reset_rf_ena", 64'(rf_ena), 64'd0);
    fin();
    cyc();
    rst = 1'b0;
    drive(1'b1, 5'd5, 32'h12345678, 1'b0, 5'd0, 32'h0);
    half();
    chk("t1_alu_ready", 64'(a_rdy), 64'd1);
`ifndef WBCK_ARB_REG_OUT_EN
    chk("t1_rf_ena", 64'(rf_ena), 64'd1);
    chk("t1_rf_idx", 64'(rf_idx), 64'd5);
    chk("t1_rf_wdat", 64'(rf_wdat), 64'h12345678);
`endif
    fin();
    chk("t1_cnt", 64'(dut.starv_cnt), 64'd0);
    drive(1'b1, 5'd3, 32'h11, 1'b1, 5'd7, 32'hA5A5A5A5);
    half();
    chk("t2_lsu_ready", 64'(l_rdy), 64'd1);
    chk("t2_alu_ready", 64'(a_rdy), 64'd0);
`ifndef WBCK_ARB_REG_OUT_EN
    chk("t2_rf_idx", 64'(rf_idx), 64'd7);
`endif
    fin();
    chk("t2_cnt", 64'(dut.starv_cnt), 64'd1);
    drive(1'b1, 5'd3, 32'h11, 1'b0, 5'd0, 32'h0);
    cyc();
    for (int i = 0; i < 6; i++) begin
      drive(1'b1, 5'd3, 32'hBEEF, 1'b1, 5'd7, 32'(32'hC000 + i));
      half();
      if (i == 4) begin
        chk("t3_prio", 64'(prio), 64'd1);
        chk("t3_alu_win", 64'(a_rdy), 64'd1);
      end else begin
        chk("t3_lsu_win", 64'(l_rdy), 64'd1);
      end
      if (i == 5) chk("t3_cnt_after", 64'(dut.starv_cnt), 64'd0);
      fin();
    end
    drive(1'b1, 5'd0, 32'hFFFFFFFF, 1'b0, 5'd0, 32'h0);
    half();
    chk("t4_alu_ready", 64'(a_rdy), 64'd1);
    chk("t4_rf_ena", 64'(rf_ena), 64'd0);
    fin();
    chk("t4_cnt", 64'(dut.starv_cnt), 64'd0);
    drive(1'b1, 5'd2, 32'h22, 1'b1, 5'd6, 32'h66);
    cyc();
    cyc();
    cyc();
    chk("t5_cnt3", 64'(dut.starv_cnt), 64'd3);
    rst = 1'b1;
    half();
    chk("t5_rst_alu_ready", 64'(a_rdy), 64'd0);
    chk("t5_rst_lsu_ready", 64'(l_rdy), 64'd0);
    fin();
    cyc();
    rst = 1'b0;
    half();
    chk("t5_lsu_first", 64'(l_rdy), 64'd1);
    chk("t5_cnt0", 64'(dut.starv_cnt), 64'd0);
    fin();
    drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
    cyc();
    drive(1'b1, 5'd9, 32'h1, 1'b0, 5'd0, 32'h0);
    cyc();
    drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
    half();
`ifdef WBCK_ARB_REG_OUT_EN
    chk("t6_rf_ena_n1", 64'(rf_ena), 64'd1);
    chk("t6_rf_idx_n1", 64'(rf_idx), 64'd9);
`endif
    fin();
    half();
    chk("t6_rf_ena_idle", 64'(rf_ena), 64'd0);
    fin();
    drive(1'b0, 5'd0, 32'h0, 1'b1, 5'd0, 32'h77);
    cyc();
    drive(1'b1, 5'd31, 32'hDEADBEEF, 1'b1, 5'd1, 32'h1234);
    for (int i = 0; i < 7; i++) cyc();
    drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
    cyc();
    cyc();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
